// File: rtl/block_lock_fsm_pkg.sv
// Shared definitions for the 66b receive path: lock FSM states and sync header codes.
// The descrambler and decoder import the sync header constants from here as well.
package block_lock_fsm_pkg;

    typedef enum logic [1:0] {
        TEST_SH   = 2'd0,
        SLIP      = 2'd1,
        SLIP_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Only the two transition codes mark a block boundary; 00 and 11 are never legal.
    function automatic logic sh_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_fsm_sh_window_cntr.sv
// Sync header test window: counts headers and invalid headers, and flags the
// outcome of the header being counted this cycle before the counters move.
module sh_window_cntr #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic invld,
    output logic window_end,
    output logic invld_limit,
    output logic window_clean
);

    localparam logic [6:0] CNT_LAST   = 7'(SH_CNT_MAX - 1);
    localparam logic [4:0] INVLD_LAST = 5'(SH_INVLD_MAX - 1);

    logic [6:0] sh_cnt;
    logic [4:0] sh_invld_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
        end else if (inc) begin
            sh_cnt <= sh_cnt + 7'd1;
            if (invld) begin
                sh_invld_cnt <= sh_invld_cnt + 5'd1;
            end
        end
    end

    // Flags describe the counts as they will be once the current header is included.
    always_comb begin
        window_end   = inc && (sh_cnt == CNT_LAST);
        invld_limit  = inc && invld && (sh_invld_cnt == INVLD_LAST);
        window_clean = (sh_invld_cnt == 5'd0) && !(inc && invld);
    end

endmodule

// File: rtl/block_lock_fsm.sv
// 66b block-lock stage: hunts for sync header alignment by slipping the gearbox,
// then forwards aligned words through one register with valids gated by lock.
module block_lock_fsm
    import block_lock_fsm_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int HDR_WIDTH    = 2,
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr,
    input  logic                  i_rx_data_valid,
    input  logic                  i_rx_hdr_valid,
    output logic                  o_slip,
    output logic                  o_block_lock,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic [HDR_WIDTH-1:0]  o_rx_sync_hdr,
    output logic                  o_rx_data_valid,
    output logic                  o_rx_hdr_valid
);

    // Handshake: there is no backpressure. A word is present when i_rx_data_valid
    // is high; i_rx_hdr_valid marks the first word of a block and only counts
    // together with i_rx_data_valid. Outputs follow the same rule one cycle later.

    localparam logic [2:0] WAIT_LOAD = 3'(SLIP_WAIT);

    state_t     state, next_state;
    logic       block_lock, next_lock;
    logic [2:0] wait_cnt, next_wait;

    logic qh;
    logic hdr_bad;
    logic cnt_inc;
    logic cnt_clear;
    logic window_end;
    logic invld_limit;
    logic window_clean;

    assign qh      = i_rx_data_valid && i_rx_hdr_valid;
    assign hdr_bad = !sh_is_valid(i_rx_sync_hdr[1:0]);
    assign cnt_inc = (state == TEST_SH) && qh;

    sh_window_cntr #(
        .SH_CNT_MAX   (SH_CNT_MAX),
        .SH_INVLD_MAX (SH_INVLD_MAX)
    ) u_sh_window_cntr (
        .clk          (i_clk),
        .reset        (i_reset),
        .clear        (cnt_clear),
        .inc          (cnt_inc),
        .invld        (hdr_bad),
        .window_end   (window_end),
        .invld_limit  (invld_limit),
        .window_clean (window_clean)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= TEST_SH;
            block_lock <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state      <= next_state;
            block_lock <= next_lock;
            wait_cnt   <= next_wait;
        end
    end

    always_comb begin
        next_state = state;
        next_lock  = block_lock;
        next_wait  = wait_cnt;
        cnt_clear  = 1'b0;
        unique case (state)
            TEST_SH: begin
                if (qh) begin
                    // The invalid-limit slip outranks a window that ends on the same header.
                    if (hdr_bad && (!block_lock || invld_limit)) begin
                        next_state = SLIP;
                        next_lock  = 1'b0;
                        cnt_clear  = 1'b1;
                    end else if (window_end) begin
                        cnt_clear = 1'b1;
                        if (window_clean) begin
                            next_lock = 1'b1;
                        end
                    end
                end
            end
            SLIP: begin
                next_state = block_lock_fsm_pkg::SLIP_WAIT;
                next_lock  = 1'b0;
                next_wait  = WAIT_LOAD;
                cnt_clear  = 1'b1;
            end
            block_lock_fsm_pkg::SLIP_WAIT: begin
                cnt_clear = 1'b1;
                if (qh) begin
                    next_wait = wait_cnt - 3'd1;
                    if (wait_cnt <= 3'd1) begin
                        next_state = TEST_SH;
                        next_wait  = '0;
                    end
                end
            end
            default: begin
                next_state = TEST_SH;
                next_lock  = 1'b0;
                next_wait  = '0;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    assign o_slip       = (state == SLIP);
    assign o_block_lock = block_lock;

    // Gating uses the lock value from before the edge, so the window-completing
    // block is dropped and the block that loses lock is still forwarded.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rx_data       <= '0;
            o_rx_sync_hdr   <= '0;
            o_rx_data_valid <= 1'b0;
            o_rx_hdr_valid  <= 1'b0;
        end else begin
            o_rx_data       <= i_rx_data;
            o_rx_sync_hdr   <= i_rx_sync_hdr;
            o_rx_data_valid <= i_rx_data_valid && block_lock;
            o_rx_hdr_valid  <= i_rx_hdr_valid && i_rx_data_valid && block_lock;
        end
    end

endmodule

// File: tb/tb_block_lock_fsm.sv
// Randomized bench for block_lock_fsm against a behavioural lock/slip model,
// with directed phases for lock acquisition, slip, loss of lock, gating and reset.
module tb_block_lock_fsm;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_rx_data = '0;
    logic [1:0]  i_rx_sync_hdr = '0;
    logic        i_rx_data_valid = 1'b0;
    logic        i_rx_hdr_valid = 1'b0;
    logic        o_slip;
    logic        o_block_lock;
    logic [31:0] o_rx_data;
    logic [1:0]  o_rx_sync_hdr;
    logic        o_rx_data_valid;
    logic        o_rx_hdr_valid;

    int check_cnt = 0;
    int fail_cnt  = 0;

    // Reference model: lock flag, headers seen in the current window, invalid
    // headers in it, headers still to ignore after a slip, and a pending slip cycle.
    bit  m_lock;
    bit  m_slip;
    int  m_win;
    int  m_bad;
    int  m_skip;
    bit  m_dv;
    bit  m_hv;
    logic [33:0] exp_q[$];
    logic [33:0] exp_word;

    block_lock_fsm dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_rx_data       (i_rx_data),
        .i_rx_sync_hdr   (i_rx_sync_hdr),
        .i_rx_data_valid (i_rx_data_valid),
        .i_rx_hdr_valid  (i_rx_hdr_valid),
        .o_slip          (o_slip),
        .o_block_lock    (o_block_lock),
        .o_rx_data       (o_rx_data),
        .o_rx_sync_hdr   (o_rx_sync_hdr),
        .o_rx_data_valid (o_rx_data_valid),
        .o_rx_hdr_valid  (o_rx_hdr_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [31:0] d, input logic [1:0] h,
                              input logic dv, input logic hv);
        bit qh;
        bit bad;
        if (rst) begin
            m_lock = 0; m_slip = 0; m_win = 0; m_bad = 0; m_skip = 0;
            m_dv = 0; m_hv = 0;
            exp_q.delete();
            exp_q.push_back('0);
            return;
        end
        m_dv = dv && m_lock;
        m_hv = dv && hv && m_lock;
        exp_q.push_back({h, d});
        qh  = dv && hv;
        bad = (h == 2'b00) || (h == 2'b11);
        if (m_slip) begin
            m_slip = 0; m_skip = 4; m_win = 0; m_bad = 0;
        end else if (m_skip > 0) begin
            if (qh) m_skip--;
        end else if (qh) begin
            m_win++;
            if (bad) m_bad++;
            if (bad && (!m_lock || m_bad == 16)) begin
                m_slip = 1; m_lock = 0; m_win = 0; m_bad = 0;
            end else if (m_win == 64) begin
                if (m_bad == 0) m_lock = 1;
                m_win = 0; m_bad = 0;
            end
        end
    endtask

    // Drive one cycle, advance the model across the edge, compare every output.
    task automatic step(input logic rst, input logic [31:0] d, input logic [1:0] h,
                        input logic dv, input logic hv);
        i_reset = rst; i_rx_data = d; i_rx_sync_hdr = h;
        i_rx_data_valid = dv; i_rx_hdr_valid = hv;
        @(posedge clk);
        model_edge(rst, d, h, dv, hv);
        #1;
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 34'd0;
        check("slip", 64'(o_slip), 64'(m_slip));
        check("block_lock", 64'(o_block_lock), 64'(m_lock));
        check("data_valid", 64'(o_rx_data_valid), 64'(m_dv));
        check("hdr_valid", 64'(o_rx_hdr_valid), 64'(m_hv));
        check("rx_data", 64'(o_rx_data), 64'(exp_word[31:0]));
        check("rx_sync_hdr", 64'(o_rx_sync_hdr), 64'(exp_word[33:32]));
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    endfunction

    task automatic do_reset();
        step(1'b1, $urandom, 2'b11, 1'b1, 1'b1);
        step(1'b1, $urandom, 2'b11, 1'b1, 1'b1);
    endtask

    task automatic good_qh();
        step(1'b0, $urandom, good_hdr(), 1'b1, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, $urandom, 2'b11, 1'b0, 1'b1);
    endtask

    // One 64-header window with 'nbad' invalid headers at random positions.
    task automatic run_window(input int nbad, input bit expect_slip);
        bit mask[64];
        int placed;
        int seen;
        int p;
        placed = 0;
        seen = 0;
        foreach (mask[i]) mask[i] = 0;
        while (placed < nbad) begin
            p = $urandom_range(0, 63);
            if (!mask[p]) begin
                mask[p] = 1;
                placed++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            step(1'b0, $urandom, mask[i] ? bad_hdr() : good_hdr(), 1'b1, 1'b1);
            if (mask[i]) seen++;
            if (expect_slip && seen == nbad) begin
                check("slip_on_limit", 64'(o_slip), 64'd1);
                check("lock_drop_on_limit", 64'(o_block_lock), 64'd0);
                return;
            end
        end
        check("lock_held_window", 64'(o_block_lock), 64'd1);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("reset_slip", 64'(o_slip), 64'd0);
        check("reset_lock", 64'(o_block_lock), 64'd0);

        // Alternating clean headers reach lock exactly at the 64th
        for (int i = 0; i < 64; i++) begin
            step(1'b0, $urandom, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1);
            if (i == 62) check("no_lock_at_63", 64'(o_block_lock), 64'd0);
        end
        check("lock_at_64", 64'(o_block_lock), 64'd1);

        // Unlocked slip, settle period ignores four bad headers, then relock
        do_reset();
        for (int i = 0; i < 10; i++) good_qh();
        step(1'b0, $urandom, 2'b00, 1'b1, 1'b1);
        check("slip_after_00", 64'(o_slip), 64'd1);
        idle();
        check("slip_one_cycle", 64'(o_slip), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, $urandom, 2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) good_qh();
        check("relock_after_slip", 64'(o_block_lock), 64'd1);

        // Locked: 15 invalid keeps lock, 16 invalid in the next window drops it
        run_window(15, 1'b0);
        run_window(16, 1'b1);

        // Idle beats between headers are not counted
        do_reset();
        for (int n = 0; n < 64; ) begin
            if ($urandom_range(0, 2) == 0) begin
                idle();
            end else if ($urandom_range(0, 4) == 0) begin
                step(1'b0, $urandom, bad_hdr(), 1'b1, 1'b0);
            end else begin
                good_qh();
                n++;
            end
        end
        check("lock_with_idles", 64'(o_block_lock), 64'd1);

        // Pass-through while locked and while unlocked
        step(1'b0, 32'hDEADBEEF, 2'b01, 1'b1, 1'b1);
        check("pt_locked_data", 64'(o_rx_data), 64'hDEADBEEF);
        check("pt_locked_dv", 64'(o_rx_data_valid), 64'd1);
        check("pt_locked_hv", 64'(o_rx_hdr_valid), 64'd1);
        do_reset();
        step(1'b0, 32'hDEADBEEF, 2'b01, 1'b1, 1'b1);
        check("pt_unlocked_data", 64'(o_rx_data), 64'hDEADBEEF);
        check("pt_unlocked_dv", 64'(o_rx_data_valid), 64'd0);
        check("pt_unlocked_hv", 64'(o_rx_hdr_valid), 64'd0);

        // Reset during the settle period, then during the slip cycle
        step(1'b0, $urandom, 2'b11, 1'b1, 1'b1);
        idle();
        good_qh();
        good_qh();
        step(1'b1, $urandom, 2'b01, 1'b1, 1'b1);
        check("rst_wait_slip", 64'(o_slip), 64'd0);
        check("rst_wait_data", 64'(o_rx_data), 64'd0);
        step(1'b0, $urandom, 2'b00, 1'b1, 1'b1);
        check("slip_before_rst", 64'(o_slip), 64'd1);
        step(1'b1, $urandom, 2'b01, 1'b1, 1'b1);
        check("rst_slip_slip", 64'(o_slip), 64'd0);
        check("rst_slip_lock", 64'(o_block_lock), 64'd0);
        for (int i = 0; i < 63; i++) good_qh();
        check("fresh_no_lock_63", 64'(o_block_lock), 64'd0);
        good_qh();
        check("fresh_lock_64", 64'(o_block_lock), 64'd1);

        // Random soak
        for (int i = 0; i < 1500; i++) begin
            logic dv;
            logic hv;
            logic [1:0] h;
            dv = ($urandom_range(0, 9) != 0);
            hv = ($urandom_range(0, 1) != 0);
            h  = ($urandom_range(0, 39) == 0) ? bad_hdr() : good_hdr();
            step(($urandom_range(0, 599) == 0), $urandom, h, dv, hv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/block_lock_fsm.md
# block_lock_fsm

Receive-side 66b block-lock stage. It sits directly downstream of the RX gearbox/block synchroniser and consumes its 32-bit data words, 2-bit sync headers and valid qualifiers. It evaluates one sync header per 66-bit block and drives the one-cycle slip request back to the gearbox until header alignment is found. Once locked, it forwards aligned data to the descrambler through a registered stage, with valid gated by lock.

## Interface
- DATA_WIDTH, 32, data word width
- HDR_WIDTH, 2, sync header width
- SH_CNT_MAX, 64, headers per test window
- SH_INVLD_MAX, 16, invalid headers per window that force loss of lock
- SLIP_WAIT, 4, qualified headers ignored after each slip (gearbox realignment settle)

- i_clk  in  1  sole clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  DATA_WIDTH  word from gearbox
- i_rx_sync_hdr  in  HDR_WIDTH  sync header of current block
- i_rx_data_valid  in  1  word valid (low on gearbox idle cycle)
- i_rx_hdr_valid  in  1  word is first half of a block; header meaningful
- o_slip  out  1  one-cycle slip request to gearbox
- o_block_lock  out  1  block lock status
- o_rx_data  out  DATA_WIDTH  registered copy of i_rx_data
- o_rx_sync_hdr  out  HDR_WIDTH  registered copy of i_rx_sync_hdr
- o_rx_data_valid  out  1  registered i_rx_data_valid AND lock
- o_rx_hdr_valid  out  1  registered i_rx_hdr_valid AND i_rx_data_valid AND lock

## Operation
- Qualified header (QH): i_rx_data_valid & i_rx_hdr_valid on a clock edge. i_rx_hdr_valid without i_rx_data_valid is ignored.
- A header is valid if it is 2'b01 or 2'b10, and invalid if it is 2'b00 or 2'b11.
- sh_cnt is 7 bits (0..SH_CNT_MAX). sh_invld_cnt is 5 bits (0..SH_INVLD_MAX). wait_cnt is 3 bits.
- States:
  - TEST_SH (entered from reset):
    - Each QH increments sh_cnt. An invalid QH also increments sh_invld_cnt.
    - Invalid QH while !block_lock → SLIP.
    - Invalid QH that makes sh_invld_cnt == SH_INVLD_MAX → SLIP. This has priority over window end.
    - QH that makes sh_cnt == SH_CNT_MAX with sh_invld_cnt == 0 → block_lock set; counters cleared; stay in TEST_SH.
    - QH that makes sh_cnt == SH_CNT_MAX with 0 < sh_invld_cnt < SH_INVLD_MAX → counters cleared; lock unchanged.
  - SLIP:
    - Lasts exactly one clock regardless of valids.
    - block_lock cleared; counters cleared; wait_cnt loaded with SLIP_WAIT → SLIP_WAIT.
  - SLIP_WAIT:
    - Each QH decrements wait_cnt. Header values are not evaluated.
    - wait_cnt reaching 0 → TEST_SH with cleared counters.
- Back-to-back slips are allowed. There is no limit on slip count; the gearbox's slip state wraps naturally.
- Pass-through path: the output registers load every clock whether or not their input valids are asserted. Only the valid outputs are gated by lock.

## Timing
- Reset values:
  - o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid = 0.
  - o_rx_data = 0, o_rx_sync_hdr = 0.
  - State = TEST_SH; all counters = 0.
- o_slip = (state == SLIP), registered. It is high exactly one cycle, in the clock after the edge that sampled the triggering QH.
- o_block_lock:
  - Rises on the edge that samples the SH_CNT_MAX-th clean QH, so it is visible the cycle after that QH is presented.
  - Falls on the same edge that enters SLIP, so it goes low together with o_slip rising.
- Data path latency is 1 cycle. Lock gating uses the registered lock value from before the edge, so the block that completes a window is not forwarded and the block that causes loss of lock still is.
- Reset asserted in any state (including mid-SLIP_WAIT or while o_slip is high) returns the block to reset values at the next edge. No slip pulse is emitted during or on exit from reset.

## Structure
- A shared package holds the state enum (TEST_SH, SLIP, SLIP_WAIT) and the valid sync header constants SYNC_DATA = 2'b01 and SYNC_CTRL = 2'b10; the descrambler and decoder also use these.
- One natural sub-module, `sh_window_cntr`: the sh_cnt/sh_invld_cnt pair with clear, increment and terminal-flag outputs. The FSM and output registers stay in the top level.

## Test plan
- Reset, then 64 QHs alternating 01/10 → o_block_lock = 1 the cycle after the 64th QH; o_slip never asserts.
- Unlocked, 10 good QHs then one QH = 00 → o_slip is high for exactly one cycle after it. The next 4 QHs (all 11) are ignored. 64 good QHs then give lock.
- Locked, 15 invalid QHs spread across one 64-QH window → lock held and counters clear at window end. Next window with 16 invalid QHs → o_slip pulses on the 16th and o_block_lock falls the same cycle.
- QHs interleaved with idle cycles (i_rx_data_valid = 0, i_rx_hdr_valid = 1, header 11) → idle beats are not counted; lock is still reached after 64 QHs.
- Locked, input 32'hDEADBEEF with header 01 → o_rx_data = 32'hDEADBEEF, o_rx_sync_hdr = 01, both valids = 1 one cycle later. The same input while unlocked → both valids = 0.
- i_reset asserted during SLIP_WAIT and during the o_slip cycle → all outputs are 0 next cycle. After release, lock requires a fresh 64 good QHs.
